mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
Sequencer for the signed 8x8 multiply-and-display datapath. It accepts a debounced start request with two operands and holds them in a one-deep pending buffer while busy. It drives the Booth multiplier, converts the signed product to sign/magnitude, then drives the binary-to-BCD converter and publishes the signed BCD word to the seven-segment display. It replaces the free-running done-chained glue with an explicit FSM, per-stage timeouts and an error flag.

Parameters:
TIMEOUT_CYCLES, 256, max cycles spent waiting in MUL_WAIT or BCD_WAIT before abort
TO_W, 9, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_CYCLES

Ports:
CLK100MHZ  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle debounced request pulse
op_a  in  8  signed multiplicand, sampled when start=1
op_b  in  8  signed multiplier, sampled when start=1
mul_valid  out  1  one-cycle launch pulse to multiplier
mul_a  out  8  operand A to multiplier, stable from launch until MUL_WAIT exits
mul_b  out  8  operand B to multiplier, stable from launch until MUL_WAIT exits
mul_done  in  1  multiplier completion pulse
mul_product  in  16  signed product, valid when mul_done=1
bcd_start  out  1  one-cycle launch pulse to BCD converter
bcd_bin  out  15  unsigned magnitude to BCD converter
bcd_done  in  1  BCD completion pulse
bcd_code  in  20  five BCD digits, valid when bcd_done=1
disp_code  out  21  {sign, 20-bit BCD} to display
busy  out  1  high in every state except IDLE
err  out  1  sticky timeout flag

Behaviour:
- Reset: state=IDLE, all outputs 0 (including disp_code and err), pending buffer empty, timeout counter 0. Reset has priority over everything and aborts any operation mid-flight, so a later mul_done or bcd_done is ignored.
- States: IDLE, MUL_LAUNCH, MUL_WAIT, SIGNMAG, BCD_LAUNCH, BCD_WAIT, PUBLISH.
- IDLE: if start=1, latch op_a/op_b into mul_a/mul_b, clear err, go to MUL_LAUNCH. Else if pending is valid, load the pending operands, clear pending and err, go to MUL_LAUNCH.
- MUL_LAUNCH: mul_valid=1 for exactly this cycle; go to MUL_WAIT; timeout counter cleared.
- MUL_WAIT: on mul_done, register the product into an internal 16-bit register and go to SIGNMAG. Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without done, set err and go to IDLE; disp_code is left unchanged.
- SIGNMAG (1 cycle):
  - sign = product[15].
  - bcd_bin = sign ? (~product + 1)[14:0] : product[14:0].
  - The range is -16256..+16384, so the magnitude always fits in 15 bits.
- BCD_LAUNCH: bcd_start=1 for one cycle; go to BCD_WAIT; counter cleared.
- BCD_WAIT: on bcd_done go to PUBLISH. The timeout rule is the same as in MUL_WAIT.
- PUBLISH (1 cycle): disp_code <= {sign, bcd_code as captured on bcd_done}; go to IDLE.
- Latency: start in cycle 0 -> mul_valid in cycle 1. If mul_done arrives in cycle M, then bcd_start is in M+2. If bcd_done arrives in cycle N, disp_code updates at the edge ending N+1.
- Pending buffer: start while busy=1 writes op_a/op_b into pending and marks it valid. A second start while pending is valid overwrites it (newest wins). Pending survives a timeout abort; reset clears it.
- A start in the same cycle the FSM is in PUBLISH goes to pending and is launched from IDLE on the next cycle.
- mul_done or bcd_done outside its WAIT state is ignored.
- mul_valid and bcd_start are never high in the same cycle, and neither is high for more than one cycle.

Decomposition:
- Package mult_pkg: state enum type seq_state_t, widths OP_W=8, PROD_W=16, MAG_W=15, BCD_W=20, DISP_W=21.
- No sub-module. Sign/magnitude is a small combinational function placed in mult_pkg (to_sign_mag) so the display path can reuse it.

Test Plan:
- 7 x -3, ideal responder models (done 8 cycles after launch) -> bcd_bin=21, disp_code=21'h1_00021, err=0, busy low after PUBLISH.
- -128 x -128 -> bcd_bin=16384, disp_code=21'h0_16384. Also 127 x -128 -> disp_code=21'h1_16256.
- start(5,5) then start(2,3) and start(4,4) while busy -> displays 25 then 16. (2,3) is never launched; exactly two mul_valid pulses.
- Multiplier model never asserts done -> err=1 after TIMEOUT_CYCLES cycles in MUL_WAIT, FSM in IDLE, disp_code retains the previous value. The next start clears err.
- reset pulsed during BCD_WAIT, then a stale bcd_done is injected -> all outputs 0, state IDLE, disp_code stays 0.
- Spurious mul_done/bcd_done while IDLE -> no state change and no output change.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types, widths and sign/magnitude helper for the multiply-and-display path
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int MAG_W  = 15;
  localparam int BCD_W  = 20;
  localparam int DISP_W = 21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_LAUNCH,
    S_MUL_WAIT,
    S_SIGNMAG,
    S_BCD_LAUNCH,
    S_BCD_WAIT,
    S_PUBLISH
  } seq_state_t;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sign_mag_t;

  // Product range is -16256..+16384, so the magnitude never needs bit 15.
  function automatic sign_mag_t to_sign_mag(input logic [PROD_W-1:0] prod);
    sign_mag_t         sm;
    logic [PROD_W-1:0] neg;
    neg     = ~prod + 1'b1;
    sm.sign = prod[PROD_W-1];
    sm.mag  = prod[PROD_W-1] ? neg[MAG_W-1:0] : prod[MAG_W-1:0];
    return sm;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - sequencer: operands -> Booth multiplier -> sign/mag -> BCD -> display
// One-deep pending buffer (newest wins), per-stage timeouts and a sticky error flag.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  output logic              mul_valid,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_product,
  output logic              bcd_start,
  output logic [MAG_W-1:0]  bcd_bin,
  input  logic              bcd_done,
  input  logic [BCD_W-1:0]  bcd_code,
  output logic [DISP_W-1:0] disp_code,
  output logic              busy,
  output logic              err
);

  seq_state_t r_state, w_next;

  logic [TO_W-1:0]   r_cnt;
  logic [OP_W-1:0]   r_mul_a, r_mul_b, r_pend_a, r_pend_b;
  logic              r_pend_valid;
  logic [PROD_W-1:0] r_product;
  logic              r_sign;
  logic [MAG_W-1:0]  r_bcd_bin;
  logic [BCD_W-1:0]  r_bcd_code;
  logic [DISP_W-1:0] r_disp;
  logic              r_err;

  logic      w_mul_valid, w_bcd_start, w_busy;
  logic      w_cnt_clr, w_cnt_inc, w_timeout, w_cnt_last;
  sign_mag_t w_sm;

  assign w_cnt_last = (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_sm       = to_sign_mag(r_product);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_mul_valid = 1'b0;
    w_bcd_start = 1'b0;
    w_busy      = 1'b1;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start || r_pend_valid) w_next = S_MUL_LAUNCH;
      end
      S_MUL_LAUNCH: begin
        w_mul_valid = 1'b1;
        w_cnt_clr   = 1'b1;
        w_next      = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (mul_done) w_next = S_SIGNMAG;
        else if (w_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else w_cnt_inc = 1'b1;
      end
      S_SIGNMAG: w_next = S_BCD_LAUNCH;
      S_BCD_LAUNCH: begin
        w_bcd_start = 1'b1;
        w_cnt_clr   = 1'b1;
        w_next      = S_BCD_WAIT;
      end
      S_BCD_WAIT: begin
        if (bcd_done) w_next = S_PUBLISH;
        else if (w_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else w_cnt_inc = 1'b1;
      end
      S_PUBLISH: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_cnt        <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_pend_a     <= '0;
      r_pend_b     <= '0;
      r_pend_valid <= 1'b0;
      r_product    <= '0;
      r_sign       <= 1'b0;
      r_bcd_bin    <= '0;
      r_bcd_code   <= '0;
      r_disp       <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_timeout) r_err <= 1'b1;

      // A fresh start in IDLE takes precedence; the pending entry waits its turn.
      if (r_state == S_IDLE) begin
        if (start) begin
          r_mul_a <= op_a;
          r_mul_b <= op_b;
          r_err   <= 1'b0;
        end else if (r_pend_valid) begin
          r_mul_a      <= r_pend_a;
          r_mul_b      <= r_pend_b;
          r_pend_valid <= 1'b0;
          r_err        <= 1'b0;
        end
      end else if (start) begin
        r_pend_a     <= op_a;
        r_pend_b     <= op_b;
        r_pend_valid <= 1'b1;
      end

      if (r_state == S_MUL_WAIT && mul_done) r_product <= mul_product;
      if (r_state == S_SIGNMAG) begin
        r_sign    <= w_sm.sign;
        r_bcd_bin <= w_sm.mag;
      end
      if (r_state == S_BCD_WAIT && bcd_done) r_bcd_code <= bcd_code;
      if (r_state == S_PUBLISH) r_disp <= {r_sign, r_bcd_code};
    end
  end

  assign mul_valid = w_mul_valid;
  assign bcd_start = w_bcd_start;
  assign busy      = w_busy;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign bcd_bin   = r_bcd_bin;
  assign disp_code = r_disp;
  assign err       = r_err;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - self-checking bench for mult_seq_ctrl with responder models
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  op_a, op_b, mul_a, mul_b;
  logic        mul_valid, mul_done, bcd_start, bcd_done, busy, err;
  logic [15:0] mul_product;
  logic [14:0] bcd_bin;
  logic [19:0] bcd_code;
  logic [20:0] disp_code;

  logic        r_mdone, inj_mdone, r_bdone, inj_bdone, mul_en;
  logic [15:0] r_mprod, inj_mprod;
  logic [19:0] r_bcode, inj_bcode;

  int total = 0, bad = 0, mv_count = 0;

  logic [15:0] exp_ops[$];
  logic [20:0] exp_d;
  int          exp_m;
  bit          exp_valid = 0;
  logic        prev_mv = 0, prev_bs = 0;
  logic [20:0] prev_disp = '0;

  always #5 clk = ~clk;

  assign mul_done    = r_mdone | inj_mdone;
  assign mul_product = inj_mdone ? inj_mprod : r_mprod;
  assign bcd_done    = r_bdone | inj_bdone;
  assign bcd_code    = inj_bdone ? inj_bcode : r_bcode;

  mult_seq_ctrl #(.TIMEOUT_CYCLES(256), .TO_W(9)) dut (
    .CLK100MHZ(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
    .mul_product(mul_product), .bcd_start(bcd_start), .bcd_bin(bcd_bin),
    .bcd_done(bcd_done), .bcd_code(bcd_code), .disp_code(disp_code),
    .busy(busy), .err(err)
  );

  function automatic logic [19:0] to_bcd_m(input int m);
    logic [19:0] r = '0;
    int v = m;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int mag_of(input int a, input int b);
    int p = a * b;
    return (p < 0) ? -p : p;
  endfunction

  function automatic logic [20:0] disp_of(input int a, input int b);
    int p = a * b;
    return {p < 0, to_bcd_m(mag_of(a, b))};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Multiplier responder: done 8 cycles after launch with the true signed product.
  initial begin
    logic signed [7:0] ra, rb;
    int p;
    r_mdone = 0; r_mprod = '0;
    forever begin
      @(negedge clk);
      if (mul_valid && mul_en) begin
        ra = mul_a; rb = mul_b;
        repeat (7) @(negedge clk);
        p = ra * rb;
        r_mprod = p[15:0];
        r_mdone = 1;
        @(negedge clk);
        r_mdone = 0;
      end
    end
  end

  // BCD responder: decimal digits of the launched magnitude, 8 cycles later.
  initial begin
    int m;
    r_bdone = 0; r_bcode = '0;
    forever begin
      @(negedge clk);
      if (bcd_start) begin
        m = int'(bcd_bin);
        repeat (7) @(negedge clk);
        r_bcode = to_bcd_m(m);
        r_bdone = 1;
        @(negedge clk);
        r_bdone = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] pair;
    int ea, eb;
    if (reset) begin
      exp_valid = 0;
      exp_ops.delete();
    end else begin
      if (mul_valid) begin
        mv_count++;
        if (exp_ops.size() == 0) check("unexpected_launch", 32'd1, 32'd0);
        else begin
          pair = exp_ops.pop_front();
          check("mul_ops", {16'b0, mul_a, mul_b}, {16'b0, pair});
          ea = int'($signed(pair[15:8]));
          eb = int'($signed(pair[7:0]));
          exp_d = disp_of(ea, eb);
          exp_m = mag_of(ea, eb);
          exp_valid = 1;
        end
      end
      if (bcd_start) check("bcd_bin", 32'(bcd_bin), 32'(exp_m));
      if (mul_valid && bcd_start) check("pulse_overlap", 32'd1, 32'd0);
      if (mul_valid && prev_mv) check("mul_valid_width", 32'd1, 32'd0);
      if (bcd_start && prev_bs) check("bcd_start_width", 32'd1, 32'd0);
      if (disp_code != prev_disp) begin
        if (!exp_valid) check("unexpected_disp", 32'(disp_code), 32'(prev_disp));
        else begin
          check("disp_code", 32'(disp_code), 32'(exp_d));
          exp_valid = 0;
        end
      end
    end
    prev_mv   = mul_valid;
    prev_bs   = bcd_start;
    prev_disp = disp_code;
  end

  task automatic pulse_start(input int a, input int b);
    start = 1; op_a = 8'(a); op_b = 8'(b);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input int a, input int b);
    exp_ops.push_back({8'(a), 8'(b)});
    pulse_start(a, b);
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mv_base, n;
    reset = 1; start = 0; op_a = 0; op_b = 0; mul_en = 1;
    inj_mdone = 0; inj_mprod = '0; inj_bdone = 0; inj_bcode = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_disp", 32'(disp_code), 0);
    check("rst_mul_valid", 32'(mul_valid), 0);
    check("rst_bcd_start", 32'(bcd_start), 0);
    check("rst_bcd_bin", 32'(bcd_bin), 0);
    check("rst_mul_ab", {16'b0, mul_a, mul_b}, 0);
    #1 reset = 0;
    @(negedge clk);

    run_op(7, -3);
    check("7x-3_bcd_bin", 32'(bcd_bin), 32'd21);
    check("7x-3_disp", 32'(disp_code), 32'h1_00021);
    check("7x-3_err", 32'(err), 0);
    check("7x-3_busy", 32'(busy), 0);

    run_op(-128, -128);
    check("m128sq_bcd_bin", 32'(bcd_bin), 32'd16384);
    check("m128sq_disp", 32'(disp_code), 32'h0_16384);
    run_op(127, -128);
    check("127xm128_disp", 32'(disp_code), 32'h1_16256);

    mv_base = mv_count;
    exp_ops.push_back({8'd5, 8'd5});
    exp_ops.push_back({8'd4, 8'd4});
    pulse_start(5, 5);
    repeat (3) @(negedge clk);
    pulse_start(2, 3);
    pulse_start(4, 4);
    wait_idle();
    check("pend_first_disp", 32'(disp_code), 32'h0_00025);
    wait_idle();
    check("pend_second_disp", 32'(disp_code), 32'h0_00016);
    check("pend_launches", 32'(mv_count - mv_base), 32'd2);

    inj_mdone = 1; inj_mprod = 16'h1234; inj_bdone = 1; inj_bcode = 20'h99999;
    @(negedge clk);
    inj_mdone = 0; inj_bdone = 0;
    @(negedge clk);
    check("spur_busy", 32'(busy), 0);
    check("spur_launch", {30'b0, mul_valid, bcd_start}, 0);
    check("spur_disp", 32'(disp_code), 32'h0_00016);
    check("spur_err", 32'(err), 0);

    mul_en = 0;
    exp_ops.push_back({8'd9, 8'd9});
    pulse_start(9, 9);
    repeat (256) @(negedge clk);
    check("to_last_wait_busy", 32'(busy), 1);
    check("to_last_wait_err", 32'(err), 0);
    @(negedge clk);
    check("to_abort_busy", 32'(busy), 0);
    check("to_abort_err", 32'(err), 1);
    check("to_disp_kept", 32'(disp_code), 32'h0_00016);
    mul_en = 1;
    @(negedge clk);

    exp_ops.push_back({8'd3, 8'd4});
    pulse_start(3, 4);
    check("err_cleared", 32'(err), 0);
    wait_idle();
    check("3x4_disp", 32'(disp_code), 32'h0_00012);

    exp_ops.push_back({8'd6, 8'd7});
    pulse_start(6, 7);
    n = 0;
    while (!bcd_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bcd_launch_seen", 32'(bcd_start), 1);
    repeat (2) @(negedge clk);
    #1 reset = 1;
    @(negedge clk);
    #1 reset = 0;
    repeat (12) @(negedge clk);
    check("mid_rst_disp", 32'(disp_code), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_bcd_bin", 32'(bcd_bin), 0);
    check("mid_rst_mul_ab", {16'b0, mul_a, mul_b}, 0);
    check("mid_rst_pulses", {30'b0, mul_valid, bcd_start}, 0);
    check("ops_left", 32'(exp_ops.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
